// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the core's fetch and load/store paths, the arbiter and the RAM.
// The arbiter connects through the master modport; the core/RAM side uses the slave modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_wstrb;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  i_req, i_addr, i_flush,
        output i_gnt, i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_ack, d_rdata,
        output m_en, m_we, m_addr, m_wdata, m_wstrb,
        input  m_rdata
    );

    modport slave (
        output i_req, i_addr, i_flush,
        input  i_gnt, i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_ack, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, m_wstrb,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch and load/store,
// one access in flight at a time, with squashable fetch responses.
//
//  state | meaning
//  IDLE  | no access in flight; grants the round-robin winner
//  ISSUE | m_en strobe with the latched request fields
//  WAIT  | counting down the remaining RAM latency
//  RESP  | m_rdata valid; ack to the owner unless the fetch was killed
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT - 1);

    state_t            state;
    logic              last_d;
    logic              kill;
    logic              own_d;
    logic              own_we;
    logic [2:0]        lat_cnt;

    logic              m_en_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [3:0]        m_wstrb_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              idle;
    logic              grant_i;
    logic              grant_d;
    logic              resp_i;
    logic              resp_d;
    logic [DATA_W-1:0] i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;

    assign idle    = (state == IDLE);
    // On a tie the fetch wins unless it was the previous grantee.
    assign grant_i = idle && bus.i_req && (!bus.d_req || last_d);
    assign grant_d = idle && bus.d_req && !grant_i;

    // A flush arriving in the response cycle itself must still squash the ack.
    assign resp_i  = (state == RESP) && !own_d && !(kill || bus.i_flush);
    assign resp_d  = (state == RESP) && own_d;

    assign i_rdata_nxt = resp_i ? bus.m_rdata : i_rdata_q;
    assign d_rdata_nxt = resp_d ? (own_we ? '0 : bus.m_rdata) : d_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            kill      <= 1'b0;
            own_d     <= 1'b0;
            own_we    <= 1'b0;
            lat_cnt   <= 3'd0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= 4'd0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    kill <= grant_i && bus.i_flush;
                    if (grant_i || grant_d) begin
                        own_d     <= grant_d;
                        own_we    <= grant_d && bus.d_we;
                        last_d    <= grant_d;
                        m_en_q    <= 1'b1;
                        m_we_q    <= grant_d && bus.d_we;
                        m_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        m_wdata_q <= (grant_d && bus.d_we) ? bus.d_wdata : '0;
                        m_wstrb_q <= (grant_d && bus.d_we) ? bus.d_wstrb : 4'd0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_en_q    <= 1'b0;
                    m_we_q    <= 1'b0;
                    m_addr_q  <= '0;
                    m_wdata_q <= '0;
                    m_wstrb_q <= 4'd0;
                    lat_cnt   <= LAT_LOAD;
                    if (!own_d && bus.i_flush) begin
                        kill <= 1'b1;
                    end
                    state <= (RAM_LAT <= 1) ? RESP : WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (!own_d && bus.i_flush) begin
                        kill <= 1'b1;
                    end
                    if (lat_cnt <= 3'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    i_rdata_q <= i_rdata_nxt;
                    d_rdata_q <= d_rdata_nxt;
                    kill      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt   = grant_i;
    assign bus.d_gnt   = grant_d;
    assign bus.i_ack   = resp_i;
    assign bus.d_ack   = resp_d;
    assign bus.i_rdata = i_rdata_nxt;
    assign bus.d_rdata = d_rdata_nxt;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LAT 1 and 3), each with a small RAM,
// checked every cycle against a transaction-timing model plus directed literal checks.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_flush;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
    } in_t;

    typedef struct packed {
        logic        i_gnt;
        logic        i_ack;
        logic [31:0] i_rdata;
        logic        d_gnt;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        m_en;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_wstrb;
    } out_t;

    typedef struct {
        bit          busy;
        int          gcyc;
        bit          own_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          killed;
        bit          last_d;
        logic [31:0] rdat;
        logic [31:0] i_rd;
        logic [31:0] d_rd;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst3_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(bus1));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3));

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM models: read data appears RAM_LAT cycles after the m_en cycle.
    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (!rst1_n) begin
            ram1[0]   <= 32'h0000_0013;
            ram1[64]  <= 32'h0;
            ram1[128] <= 32'h55AA_55AA;
            p1        <= 32'h0;
        end else if (bus1.m_en) begin
            if (bus1.m_we) ram1[widx(bus1.m_addr)] <= merge(ram1[widx(bus1.m_addr)], bus1.m_wdata, bus1.m_wstrb);
            else           p1 <= ram1[widx(bus1.m_addr)];
        end
    end

    always @(posedge clk) begin
        if (!rst3_n) begin
            ram3[0]   <= 32'h0000_0013;
            ram3[64]  <= 32'h0;
            ram3[128] <= 32'h55AA_55AA;
            p3[0] <= 32'h0;
            p3[1] <= 32'h0;
            p3[2] <= 32'h0;
        end else begin
            p3[1] <= p3[0];
            p3[2] <= p3[1];
            if (bus3.m_en && bus3.m_we) ram3[widx(bus3.m_addr)] <= merge(ram3[widx(bus3.m_addr)], bus3.m_wdata, bus3.m_wstrb);
            if (bus3.m_en && !bus3.m_we) p3[0] <= ram3[widx(bus3.m_addr)];
        end
    end

    assign bus1.m_rdata = p1;
    assign bus3.m_rdata = p3[2];

    in_t  in1, in3;
    out_t out1, out3;
    assign in1  = {bus1.i_req, bus1.i_addr, bus1.i_flush, bus1.d_req, bus1.d_we, bus1.d_addr, bus1.d_wdata, bus1.d_wstrb};
    assign in3  = {bus3.i_req, bus3.i_addr, bus3.i_flush, bus3.d_req, bus3.d_we, bus3.d_addr, bus3.d_wdata, bus3.d_wstrb};
    assign out1 = {bus1.i_gnt, bus1.i_ack, bus1.i_rdata, bus1.d_gnt, bus1.d_ack, bus1.d_rdata,
                   bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wdata, bus1.m_wstrb};
    assign out3 = {bus3.i_gnt, bus3.i_ack, bus3.i_rdata, bus3.d_gnt, bus3.d_ack, bus3.d_rdata,
                   bus3.m_en, bus3.m_we, bus3.m_addr, bus3.m_wdata, bus3.m_wstrb};

    logic [31:0] ref_mem [256];
    mdl_t m1, m3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.busy = 0; m.gcyc = 0; m.own_d = 0; m.we = 0;
        m.addr = '0; m.wdata = '0; m.strb = '0; m.killed = 0;
        m.last_d = 1; m.rdat = '0; m.i_rd = '0; m.d_rd = '0;
        return m;
    endfunction

    // Timing model: grant at T, strobe at T+1, response at T+1+lat, free again at T+2+lat.
    task automatic model_step(inout mdl_t m, input logic rst_n, input int lat,
                              input in_t in, input out_t o, input string tag);
        out_t e;
        bit   cmp_wdata;
        e = '0;
        cmp_wdata = 1;
        if (!rst_n) begin
            m = mdl_reset();
        end else begin
            e.i_rdata = m.i_rd;
            e.d_rdata = m.d_rd;
            if (!m.busy) begin
                if (in.i_req && (!in.d_req || m.last_d)) e.i_gnt = 1'b1;
                else if (in.d_req)                       e.d_gnt = 1'b1;
                if (e.i_gnt || e.d_gnt) begin
                    m.busy   = 1;
                    m.gcyc   = cyc;
                    m.own_d  = e.d_gnt;
                    m.we     = e.d_gnt && in.d_we;
                    m.addr   = e.d_gnt ? in.d_addr : in.i_addr;
                    m.wdata  = in.d_wdata;
                    m.strb   = in.d_wstrb;
                    m.killed = e.i_gnt && in.i_flush;
                    m.last_d = e.d_gnt;
                end
            end else begin
                if (!m.own_d && in.i_flush) m.killed = 1;
                if (cyc == m.gcyc + 1) begin
                    e.m_en   = 1'b1;
                    e.m_we   = m.we;
                    e.m_addr = m.addr;
                    if (m.we) begin
                        e.m_wdata = m.wdata;
                        e.m_wstrb = m.strb;
                        ref_mem[widx(m.addr)] = merge(ref_mem[widx(m.addr)], m.wdata, m.strb);
                    end else begin
                        cmp_wdata = 0;
                        m.rdat = ref_mem[widx(m.addr)];
                    end
                end
                if (cyc == m.gcyc + 1 + lat) begin
                    if (m.own_d) begin
                        e.d_ack   = 1'b1;
                        m.d_rd    = m.we ? 32'h0 : m.rdat;
                        e.d_rdata = m.d_rd;
                    end else if (!m.killed) begin
                        e.i_ack   = 1'b1;
                        m.i_rd    = m.rdat;
                        e.i_rdata = m.i_rd;
                    end
                    m.busy = 0;
                end
            end
        end
        chk({tag, ".i_gnt"},   32'(o.i_gnt),   32'(e.i_gnt));
        chk({tag, ".d_gnt"},   32'(o.d_gnt),   32'(e.d_gnt));
        chk({tag, ".i_ack"},   32'(o.i_ack),   32'(e.i_ack));
        chk({tag, ".d_ack"},   32'(o.d_ack),   32'(e.d_ack));
        chk({tag, ".i_rdata"}, o.i_rdata,      e.i_rdata);
        chk({tag, ".d_rdata"}, o.d_rdata,      e.d_rdata);
        chk({tag, ".m_en"},    32'(o.m_en),    32'(e.m_en));
        chk({tag, ".m_we"},    32'(o.m_we),    32'(e.m_we));
        chk({tag, ".m_addr"},  o.m_addr,       e.m_addr);
        chk({tag, ".m_wstrb"}, 32'(o.m_wstrb), 32'(e.m_wstrb));
        if (cmp_wdata) chk({tag, ".m_wdata"}, o.m_wdata, e.m_wdata);
    endtask

    // One access on the RAM_LAT=1 instance; returns to the caller in the first free cycle.
    task automatic access1(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int fl_off,
                           output int tg, output int ta, output logic [31:0] rd,
                           output bit men_seen, output bit mwe_seen);
        tg = -1; ta = -1; rd = '0; men_seen = 0; mwe_seen = 0;
        if (is_d) begin
            bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wd; bus1.d_wstrb = st;
        end else begin
            bus1.i_req = 1'b1; bus1.i_addr = addr;
        end
        for (int k = 0; k < 20 && tg < 0; k++) begin
            @(negedge clk);
            if (is_d ? bus1.d_gnt : bus1.i_gnt) tg = cyc;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
        if (tg < 0) begin
            chk("grant_timeout", 32'd0, 32'd1);
            return;
        end
        while (cyc < tg + 3) begin
            bus1.i_flush = (cyc - tg == fl_off);
            @(negedge clk);
            if (bus1.m_en) begin men_seen = 1; mwe_seen = bus1.m_we; end
            if ((is_d ? bus1.d_ack : bus1.i_ack) && ta < 0) begin
                ta = cyc;
                rd = is_d ? bus1.d_rdata : bus1.i_rdata;
            end
            @(posedge clk); #1;
        end
        bus1.i_flush = 1'b0;
    endtask

    int          tg, ta, tg2, ta2, n, ovl, nack, ia;
    logic [31:0] rd, rd2, ird;
    bit          men, mwe, men2, mwe2;
    logic [5:0]  order;
    int          gc [6];

    initial begin
        bus1.i_req = 0; bus1.i_addr = 0; bus1.i_flush = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_wstrb = 0;
        bus3.i_req = 0; bus3.i_addr = 0; bus3.i_flush = 0; bus3.d_req = 0; bus3.d_we = 0;
        bus3.d_addr = 0; bus3.d_wdata = 0; bus3.d_wstrb = 0;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[0]   = 32'h0000_0013;
        ref_mem[128] = 32'h55AA_55AA;
        m1 = mdl_reset();
        m3 = mdl_reset();
        for (int i = 0; i < 6; i++) gc[i] = 0;

        fork
            forever begin
                @(negedge clk);
                model_step(m1, rst1_n, 1, in1, out1, "lat1");
                model_step(m3, rst3_n, 3, in3, out3, "lat3");
            end
            begin
                #100000;
                $display("FAIL global_timeout");
                $fatal(1, "bench did not finish");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk); #1;

        // Single fetch after reset
        access1(0, 0, 32'h0080_0000, 32'h0, 4'h0, -1, tg, ta, rd, men, mwe);
        chk("fetch_ack_latency", 32'(ta - tg), 32'd2);
        chk("fetch_rdata", rd, 32'h0000_0013);
        chk("fetch_m_en", 32'(men), 32'd1);
        chk("fetch_m_we", 32'(mwe), 32'd0);

        // Store then load of the same word
        access1(1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, -1, tg, ta, rd, men, mwe);
        access1(1, 0, 32'h100, 32'h0, 4'h0, -1, tg2, ta2, rd2, men2, mwe2);
        chk("store_m_we", 32'(mwe), 32'd1);
        chk("store_ack_latency", 32'(ta - tg), 32'd2);
        chk("store_rdata_zero", rd, 32'h0);
        chk("load_rdata", rd2, 32'hDEAD_BEEF);
        chk("store_load_gap", 32'(tg2 - tg), 32'd3);

        // Both requesters held high for six accesses
        bus1.i_req = 1; bus1.i_addr = 32'h0080_0000;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h100;
        n = 0; ovl = 0; order = '0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk);
            if ((bus1.i_gnt || bus1.d_gnt) && (bus1.i_ack || bus1.d_ack)) ovl++;
            if (bus1.i_gnt || bus1.d_gnt) begin
                order[n] = bus1.d_gnt;
                gc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        bus1.i_req = 0;
        bus1.d_req = 0;
        chk("tie_grant_count", 32'(n), 32'd6);
        chk("tie_grant_order", 32'(order), 32'b101010);
        chk("tie_grant_span", 32'(gc[5] - gc[0]), 32'd15);
        chk("tie_ack_gnt_overlap", 32'(ovl), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Fetch flushed one cycle after grant, then a load right behind it
        access1(0, 0, 32'h0080_0000, 32'h0, 4'h0, 1, tg, ta, rd, men, mwe);
        access1(1, 0, 32'h100, 32'h0, 4'h0, -1, tg2, ta2, rd2, men2, mwe2);
        chk("flush_m_en_fires", 32'(men), 32'd1);
        chk("flush_no_i_ack", 32'(ta), 32'hFFFF_FFFF);
        chk("flush_next_grant", 32'(tg2 - tg), 32'd3);

        // Flush in the response cycle itself
        access1(0, 0, 32'h0080_0000, 32'h0, 4'h0, 2, tg, ta, rd, men, mwe);
        chk("flush_resp_no_i_ack", 32'(ta), 32'hFFFF_FFFF);

        // Flush has no effect on a data access
        access1(1, 0, 32'h100, 32'h0, 4'h0, 1, tg, ta, rd, men, mwe);
        chk("flush_data_ack", 32'(ta - tg), 32'd2);
        chk("flush_data_rdata", rd, 32'hDEAD_BEEF);

        // RAM_LAT=3: load aborted by reset two cycles after grant
        bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h200;
        tg = -1;
        for (int k = 0; k < 20 && tg < 0; k++) begin
            @(negedge clk);
            if (bus3.d_gnt) tg = cyc;
            else begin @(posedge clk); #1; end
        end
        chk("lat3_load_granted", 32'(tg >= 0), 32'd1);
        @(posedge clk); #1;
        bus3.d_req = 0;
        @(posedge clk); #1;
        rst3_n = 1'b0;
        #1;
        chk("lat3_reset_outputs_zero",
            32'(|{bus3.i_gnt, bus3.i_ack, bus3.d_gnt, bus3.d_ack, bus3.m_en, bus3.m_we, bus3.m_addr,
                  bus3.m_wdata, bus3.m_wstrb, bus3.i_rdata, bus3.d_rdata}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        nack = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus3.d_ack) nack++;
        end
        chk("lat3_no_ack_after_reset", 32'(nack), 32'd0);
        @(posedge clk); #1;

        // Tie after reset goes to the fetch; full latency-3 period
        bus3.i_req = 1; bus3.i_addr = 32'h0080_0000;
        bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h200;
        n = 0; ia = -1; ird = '0; order = '0;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge clk);
            if (bus3.i_gnt || bus3.d_gnt) begin
                order[n] = bus3.d_gnt;
                gc[n] = cyc;
                n++;
            end
            if (bus3.i_ack && ia < 0) begin ia = cyc; ird = bus3.i_rdata; end
            @(posedge clk); #1;
        end
        bus3.i_req = 0;
        bus3.d_req = 0;
        chk("lat3_tie_count", 32'(n), 32'd2);
        chk("lat3_tie_first_fetch", 32'(order[1:0]), 32'b10);
        chk("lat3_grant_gap", 32'(gc[1] - gc[0]), 32'd5);
        chk("lat3_fetch_ack_latency", 32'(ia - gc[0]), 32'd4);
        chk("lat3_fetch_rdata", ird, 32'h0000_0013);
        repeat (8) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single RAM port between the core's instruction-fetch path and its load/store path.
- Requesters use a req/gnt/ack handshake. Only one access is in flight at a time.
- Ties are resolved round-robin. Instruction responses can be squashed on a taken branch or jump.
- Sits between `risc_core` and `ram`. The core no longer drives RAM address or write-enable directly.

## Interface
- `ADDR_W`, 32, address width for both requesters and the RAM side.
- `DATA_W`, 32, data width.
- `RAM_LAT`, 1, cycles from the `m_en` cycle until `m_rdata` is valid; legal range is 1..7.
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction fetch request; held high until `i_gnt`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_flush`  in  1  discards the in-flight fetch response.
- `i_gnt`  out  1  fetch request accepted; combinational.
- `i_ack`  out  1  one-cycle pulse; fetch data valid.
- `i_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  data request; held high until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  4  store byte enables.
- `d_gnt`  out  1  data request accepted; combinational.
- `d_ack`  out  1  one-cycle pulse; load data valid or store complete.
- `d_rdata`  out  DATA_W  load data; 0 on a store ack.
- `m_en`  out  1  RAM access strobe, one cycle per access.
- `m_we`  out  1  RAM write enable; valid with `m_en`.
- `m_addr`  out  ADDR_W  RAM address.
- `m_wdata`  out  DATA_W  RAM write data.
- `m_wstrb`  out  4  RAM byte enables; 0 on reads.
- `m_rdata`  in  DATA_W  RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grants when any `req` is high. A grant in cycle T latches the owner, address, `we`, `wdata` and `wstrb`, then moves to ISSUE.
  - Only one request: that requester is granted.
  - Both requesting: grant goes to the requester not granted last, tracked by the `last_d` flag. `last_d` resets to 1, so the fetch wins the first tie.
  - `last_d` updates on every grant.
- ISSUE: drive `m_en` high with the latched fields for exactly one cycle. Load `lat_cnt` = RAM_LAT−1, then go to WAIT, or to RESP when RAM_LAT = 1.
- WAIT: decrement `lat_cnt`; go to RESP when it reaches 0.
- RESP:
  - Capture `m_rdata` and raise the owner's `ack` with its `rdata` for this one cycle, then return to IDLE.
  - A store ack drives `d_rdata` = 0.
- `gnt` is asserted only in IDLE. A requester that drops `req` before grant is never serviced.
- Flush:
  - `i_flush` high in any cycle from the fetch grant through RESP, inclusive, sets `kill`.
  - A killed fetch completes its RAM access but `i_ack` stays low.
  - `kill` clears on return to IDLE.
  - `i_flush` has no effect on data accesses.
- `i_rdata` and `d_rdata` hold their last value between acks. Consumers sample them only with `ack`.
- Outputs for the non-owner, and `m_*` outside ISSUE, are 0, except `*_rdata`, which hold their last value.

## Timing
- Reset values: state = IDLE, `last_d` = 1, `kill` = 0, `lat_cnt` = 0. All outputs are 0, including `*_rdata`.
- Grant at T gives `m_en` at T+1 and `ack` at T+1+RAM_LAT.
- Next grant possible at T+2+RAM_LAT. Back-to-back period is RAM_LAT+2 cycles.
- A request raised while busy waits. It is granted in the first IDLE cycle, subject to the round-robin rule.
- `i_flush` in the RESP cycle itself still suppresses `i_ack`. The flag is combinationally ORed into the ack gate.
- Reset asserted mid-access:
  - Immediate return to IDLE; no ack is ever produced for the aborted access.
  - `m_en` drops asynchronously.
  - A RAM write already strobed in ISSUE is not undone.
- `gnt` is never asserted together with any `ack` from the same access. `i_gnt` and `d_gnt` are never asserted together.

## Test plan
- Reset, then `i_req` = 1, `i_addr` = 0x800000, RAM word = 0x00000013, RAM_LAT = 1:
  - `i_gnt` at T, `m_en` at T+1 with `m_addr` = 0x800000, `m_we` = 0.
  - `i_ack` at T+2 with `i_rdata` = 0x00000013.
- Store `d_addr` = 0x100, `d_wdata` = 0xDEADBEEF, `d_wstrb` = 0xF, followed by a load of 0x100:
  - Store: `m_we` = 1 and `d_ack` with `d_rdata` = 0.
  - Load: returns 0xDEADBEEF, with the second grant exactly 3 cycles after the first.
- `i_req` and `d_req` held high continuously for 6 accesses:
  - Grant order I, D, I, D, I, D; no ack overlaps a grant.
- Fetch granted, then `i_flush` pulsed at T+1:
  - `m_en` still fires; `i_ack` never rises; the next grant occurs at T+3.
- RAM_LAT = 3, load granted, `reset_n` pulled low at T+2:
  - All outputs 0 immediately; no `d_ack` after release.
  - A subsequent tie is granted to the fetch first.
